i2c_sb_sequencer: RTL and testbench
===================================

# i2c_sb_sequencer

Command-level front end for the iCE40UP hard I2C controller in master mode. Accepts one register-write or register-read command at a time (7-bit device, 8-bit register, 8-bit data) and expands it into the system-bus (SB) register accesses, status polling, STOP generation and error handling the hard IP needs. Sits directly upstream of the I2C hard-IP wrapper: its SB master port drives that block's SBSTBI/SBRWI/SBADRI/SBDATI and samples SBDATO/SBACKO.

## Interface
- BUS_ADDR74, 4'b0001: SB address high nibble of the target I2C instance; must match the instance's BUS_ADDR74.
- PRESCALE, 10'd60: written to BRLSB = PRESCALE[7:0] and BRMSB = {6'b0, PRESCALE[9:8]}.
- TIMEOUT_CYCLES, 16'd65535: maximum clk cycles spent in any single status wait.

Ports:
- clk  in  1  sole clock, also drives the IP's SBCLKI.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1; cmd_ready  out  1: command handshake, accepted on valid & ready.
- cmd_rd  in  1: 1 = register read, 0 = register write.
- cmd_dev  in  7; cmd_reg  in  8; cmd_wdata  in  8: device address, register address, write data.
- rsp_valid  out  1: one-cycle completion pulse.
- rsp_rdata  out  8: read byte, 0 for writes and errors.
- rsp_err  out  2: 00 ok, 01 NACK, 10 timeout, 11 arbitration lost.
- sb_stb  out  1; sb_rw  out  1 (1 = write); sb_adr  out  8; sb_wdat  out  8: SB request.
- sb_rdat  in  8; sb_ack  in  1: SB response.

## Operation
- SB offsets (low nibble): CR1 8, CMDR 9, BRLSB A, BRMSB B, SR C, TXDR D, RXDR E; sb_adr = {BUS_ADDR74, offset}.
- CMDR values: START_WR 0x94, WR 0x14, STOP 0x44, RD_NACK_STOP 0x6C. SR bits: TIP 7, BUSY 6, RARC 5, ARBL 3, TRRDY 2.
- States: INIT → IDLE → ADDR → (WDATA | RSTART → RDATA) → STOP → IDLE; ABORT on any error.
- INIT: write BRLSB, BRMSB, then CR1 = 0x80. cmd_ready = 0 throughout.
- IDLE: cmd_ready = 1; latch all cmd_* fields on acceptance.
- ADDR: TXDR ← {dev,0}; CMDR ← START_WR; wait TRRDY; TXDR ← reg; CMDR ← WR; wait TRRDY.
- WDATA: TXDR ← wdata; CMDR ← WR; wait TRRDY; then STOP.
- RSTART: TXDR ← {dev,1}; CMDR ← START_WR; wait TRRDY.
- RDATA: CMDR ← RD_NACK_STOP; wait TRRDY; read RXDR into rsp_rdata.
- STOP: CMDR ← STOP (write only; RDATA already stopped); wait BUSY = 0; respond with err 00.
- Wait = repeated SR reads, one access per poll. Each SR read checks in priority order: ARBL → err 11; RARC after an address/data byte → err 01; then the wait condition.
- ABORT: single CMDR ← STOP write (no BUSY wait), then respond with the latched error and return to IDLE.
- Timeout: 16-bit counter cleared on entering each wait, increments every clk in the wait; reaching TIMEOUT_CYCLES → err 10 → ABORT.

## Timing
- Reset values: cmd_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, sb_stb 0, sb_rw 0, sb_adr 0, sb_wdat 0. State = INIT.
- SB access: sb_stb, sb_rw, sb_adr and sb_wdat are stable from assertion until the cycle sb_ack = 1 is sampled. sb_rdat is captured in that cycle. sb_stb = 0 for at least one cycle before the next access, so an access costs at least 3 cycles.
- cmd_ready drops the cycle after acceptance.
- rsp_valid pulses in the cycle the FSM re-enters IDLE, with cmd_ready = 1 in the same cycle. A command offered in that cycle is accepted.
- rsp_rdata and rsp_err hold until the next rsp_valid.
- rst asserted mid-transfer: next cycle all outputs take reset values, sb_stb drops even without ack, no STOP is issued, and INIT reruns.
- sb_ack while sb_stb = 0 is ignored.

## Structure
- Package i2c_sb_pkg: offset constants, CMDR command constants, SR bit indices, rsp_err encodings, FSM state enum.
- Sub-module sb_xact: single SB access engine with start/done, holding the stb/ack handshake and the idle-gap rule. The sequencer FSM issues micro-steps to it.

## Test plan
All scenarios use BUS_ADDR74 = 1, PRESCALE = 60, and an SB model of the IP.
- Reset release → SB writes 0x1A=0x3C, 0x1B=0x00, 0x18=0x80 in order; cmd_ready rises after the third ack.
- Write dev 0x3C, reg 0x12, data 0xA5, all ACKed → writes 0x1D=0x78, 0x19=0x94, 0x1D=0x12, 0x19=0x14, 0x1D=0xA5, 0x19=0x14, 0x19=0x44 with SR polls between; rsp_err 00, rsp_rdata 0.
- Read dev 0x24, reg 0x00, model RXDR = 0x5A → TXDR 0x48, 0x00, 0x49; CMDR 0x6C; read 0x1E; rsp_rdata 0x5A, err 00.
- RARC = 1 after address byte → single 0x19=0x44 write, no further TXDR writes, rsp_err 01.
- TRRDY never set, TIMEOUT_CYCLES = 100 → rsp_err 10 no later than 100 cycles plus one SB access after the wait starts; STOP written; then ARBL = 1 on a fresh command → rsp_err 11.
- rst pulsed while sb_stb = 1 during a poll → sb_stb = 0 next cycle; the INIT write sequence repeats; no rsp_valid is produced.

Source files
------------

// File: rtl/i2c_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sb_pkg
// Description : Shared constants and types for the iCE40UP hard-I2C command
//               sequencer: SB register offsets, CMDR opcodes, SR bit
//               positions, response codes and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_sb_pkg;

    // SB register offsets (low address nibble)
    localparam logic [3:0] OFF_CR1   = 4'h8;
    localparam logic [3:0] OFF_CMDR  = 4'h9;
    localparam logic [3:0] OFF_BRLSB = 4'hA;
    localparam logic [3:0] OFF_BRMSB = 4'hB;
    localparam logic [3:0] OFF_SR    = 4'hC;
    localparam logic [3:0] OFF_TXDR  = 4'hD;
    localparam logic [3:0] OFF_RXDR  = 4'hE;

    // CMDR opcodes and control values
    localparam logic [7:0] CMD_START_WR     = 8'h94;
    localparam logic [7:0] CMD_WR           = 8'h14;
    localparam logic [7:0] CMD_STOP         = 8'h44;
    localparam logic [7:0] CMD_RD_NACK_STOP = 8'h6C;
    localparam logic [7:0] CR1_ENABLE       = 8'h80;

    // SR bit positions
    localparam int SR_TIP   = 7;
    localparam int SR_BUSY  = 6;
    localparam int SR_RARC  = 5;
    localparam int SR_ARBL  = 3;
    localparam int SR_TRRDY = 2;

    // Response error codes
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ARBL    = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WDATA  = 3'd3,
        ST_RSTART = 3'd4,
        ST_RDATA  = 3'd5,
        ST_STOP   = 3'd6,
        ST_ABORT  = 3'd7
    } state_t;

    // One micro-step of a state: either a single SB access or an SR poll loop
    typedef struct packed {
        logic       rw;        // 1 = SB write
        logic [3:0] off;       // register offset
        logic [7:0] data;      // write data
        logic       poll;      // repeated SR reads until the wait condition holds
        logic       poll_busy; // wait for BUSY = 0 instead of TRRDY = 1
        logic       nack_chk;  // poll follows a transmitted byte: RARC means NACK
        logic       last;      // final micro-step of the state
    } step_t;

endpackage : i2c_sb_pkg
`default_nettype wire

// File: rtl/sb_xact.sv
`default_nettype none
// ============================================================================
// Module      : sb_xact
// Description : Single system-bus access engine. Holds the request stable
//               until ack, reports completion combinationally in the ack
//               cycle and forces at least one idle cycle between accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_xact (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] adr,
    input  logic [7:0] wdat,
    output logic       idle,
    output logic       done,
    output logic [7:0] rdat,
    output logic       sb_stb,
    output logic       sb_rw,
    output logic [7:0] sb_adr,
    output logic [7:0] sb_wdat,
    input  logic [7:0] sb_rdat,
    input  logic       sb_ack
);

    // A start is only taken while strobe is low, so the cycle after an ack
    // is always an idle gap on the bus.
    assign idle = ~sb_stb;
    assign done = sb_stb & sb_ack;
    assign rdat = sb_rdat;

    // Request register: launch on start, release on ack, ignore stray acks
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_stb  <= 1'b0;
            sb_rw   <= 1'b0;
            sb_adr  <= 8'h00;
            sb_wdat <= 8'h00;
        end else if (sb_stb) begin
            if (sb_ack) begin
                sb_stb <= 1'b0;
            end
        end else if (start) begin
            sb_stb  <= 1'b1;
            sb_rw   <= rw;
            sb_adr  <= adr;
            sb_wdat <= wdat;
        end
    end

endmodule : sb_xact
`default_nettype wire

// File: rtl/i2c_sb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sb_sequencer
// Description : Command-level front end for the iCE40UP hard I2C master.
//               Expands one register read/write command into SB register
//               accesses, SR polling, STOP generation and error handling.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sb_sequencer
    import i2c_sb_pkg::*;
#(
    parameter logic [3:0]  BUS_ADDR74     = 4'b0001,
    parameter logic [9:0]  PRESCALE       = 10'd60,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       sb_stb,
    output logic       sb_rw,
    output logic [7:0] sb_adr,
    output logic [7:0] sb_wdat,
    input  logic [7:0] sb_rdat,
    input  logic       sb_ack
);

    state_t      state, state_n;
    logic [2:0]  step, step_n;
    logic        lat_rd, lat_rd_n;
    logic [6:0]  lat_dev, lat_dev_n;
    logic [7:0]  lat_reg, lat_reg_n;
    logic [7:0]  lat_wdata, lat_wdata_n;
    logic [7:0]  rdata_q, rdata_n;
    logic [1:0]  err_q, err_n;
    logic [15:0] wait_cnt, wait_cnt_n;
    logic        rsp_valid_n;
    logic [7:0]  rsp_rdata_n;
    logic [1:0]  rsp_err_n;

    step_t       op;
    logic        advance;
    logic        timed_out;
    logic        xact_start, xact_idle, xact_done;
    logic [7:0]  xact_rdat;

    assign cmd_ready = (state == ST_IDLE);
    assign timed_out = (wait_cnt >= TIMEOUT_CYCLES);

    sb_xact u_xact (
        .clk     (clk),
        .rst     (rst),
        .start   (xact_start),
        .rw      (op.rw),
        .adr     ({BUS_ADDR74, op.off}),
        .wdat    (op.data),
        .idle    (xact_idle),
        .done    (xact_done),
        .rdat    (xact_rdat),
        .sb_stb  (sb_stb),
        .sb_rw   (sb_rw),
        .sb_adr  (sb_adr),
        .sb_wdat (sb_wdat),
        .sb_rdat (sb_rdat),
        .sb_ack  (sb_ack)
    );

    // Micro-step decode: what access the current state/step performs
    always_comb begin
        op = '{rw: 1'b1, off: OFF_CMDR, data: CMD_STOP, poll: 1'b0,
               poll_busy: 1'b0, nack_chk: 1'b0, last: 1'b0};
        unique case (state)
            ST_INIT: begin
                case (step)
                    3'd0:    begin op.off = OFF_BRLSB; op.data = PRESCALE[7:0]; end
                    3'd1:    begin op.off = OFF_BRMSB; op.data = {6'b0, PRESCALE[9:8]}; end
                    default: begin op.off = OFF_CR1; op.data = CR1_ENABLE; op.last = 1'b1; end
                endcase
            end
            ST_ADDR: begin
                case (step)
                    3'd0:    begin op.off = OFF_TXDR; op.data = {lat_dev, 1'b0}; end
                    3'd1:    op.data = CMD_START_WR;
                    3'd2:    begin op.rw = 1'b0; op.off = OFF_SR; op.data = 8'h00;
                                   op.poll = 1'b1; op.nack_chk = 1'b1; end
                    3'd3:    begin op.off = OFF_TXDR; op.data = lat_reg; end
                    3'd4:    op.data = CMD_WR;
                    default: begin op.rw = 1'b0; op.off = OFF_SR; op.data = 8'h00;
                                   op.poll = 1'b1; op.nack_chk = 1'b1; op.last = 1'b1; end
                endcase
            end
            ST_WDATA, ST_RSTART: begin
                case (step)
                    3'd0:    begin op.off = OFF_TXDR;
                                   op.data = (state == ST_WDATA) ? lat_wdata : {lat_dev, 1'b1}; end
                    3'd1:    op.data = (state == ST_WDATA) ? CMD_WR : CMD_START_WR;
                    default: begin op.rw = 1'b0; op.off = OFF_SR; op.data = 8'h00;
                                   op.poll = 1'b1; op.nack_chk = 1'b1; op.last = 1'b1; end
                endcase
            end
            ST_RDATA: begin
                // The read byte is NACKed by us, so RARC is expected here
                case (step)
                    3'd0:    op.data = CMD_RD_NACK_STOP;
                    3'd1:    begin op.rw = 1'b0; op.off = OFF_SR; op.data = 8'h00; op.poll = 1'b1; end
                    default: begin op.rw = 1'b0; op.off = OFF_RXDR; op.data = 8'h00; op.last = 1'b1; end
                endcase
            end
            ST_STOP: begin
                if (step != 3'd0) begin
                    op.rw        = 1'b0;
                    op.off       = OFF_SR;
                    op.data      = 8'h00;
                    op.poll      = 1'b1;
                    op.poll_busy = 1'b1;
                    op.last      = 1'b1;
                end
            end
            ST_ABORT: op.last = 1'b1;
            default: ;
        endcase
    end

    // Next-state logic: step through accesses, evaluate SR polls, respond
    always_comb begin
        state_n     = state;
        step_n      = step;
        lat_rd_n    = lat_rd;
        lat_dev_n   = lat_dev;
        lat_reg_n   = lat_reg;
        lat_wdata_n = lat_wdata;
        rdata_n     = rdata_q;
        err_n       = err_q;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        xact_start  = 1'b0;
        advance     = 1'b0;
        // Wait counter only runs inside a poll step; any other step clears it
        wait_cnt_n  = op.poll ? (timed_out ? wait_cnt : wait_cnt + 16'd1) : 16'd0;

        if (state == ST_IDLE) begin
            if (cmd_valid) begin
                lat_rd_n    = cmd_rd;
                lat_dev_n   = cmd_dev;
                lat_reg_n   = cmd_reg;
                lat_wdata_n = cmd_wdata;
                rdata_n     = 8'h00;
                err_n       = ERR_OK;
                state_n     = ST_ADDR;
                step_n      = 3'd0;
            end
        end else begin
            if (xact_idle) begin
                if (op.poll && timed_out) begin
                    err_n   = ERR_TIMEOUT;
                    state_n = ST_ABORT;
                    step_n  = 3'd0;
                end else begin
                    xact_start = 1'b1;
                end
            end

            if (xact_done) begin
                if (op.poll) begin
                    if (xact_rdat[SR_ARBL]) begin
                        err_n   = ERR_ARBL;
                        state_n = ST_ABORT;
                        step_n  = 3'd0;
                    end else if (op.nack_chk && xact_rdat[SR_RARC]) begin
                        err_n   = ERR_NACK;
                        state_n = ST_ABORT;
                        step_n  = 3'd0;
                    end else if (op.poll_busy ? !xact_rdat[SR_BUSY] : xact_rdat[SR_TRRDY]) begin
                        advance = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                    if (!op.rw) begin
                        rdata_n = xact_rdat;
                    end
                end
            end

            if (advance) begin
                if (!op.last) begin
                    step_n = step + 3'd1;
                end else begin
                    step_n = 3'd0;
                    case (state)
                        ST_INIT:   state_n = ST_IDLE;
                        ST_ADDR:   state_n = lat_rd ? ST_RSTART : ST_WDATA;
                        ST_WDATA:  state_n = ST_STOP;
                        ST_RSTART: state_n = ST_RDATA;
                        ST_RDATA: begin
                            // RD_NACK_STOP already issued the STOP; go straight to BUSY wait
                            state_n = ST_STOP;
                            step_n  = 3'd1;
                        end
                        ST_STOP: begin
                            state_n     = ST_IDLE;
                            rsp_valid_n = 1'b1;
                            rsp_err_n   = ERR_OK;
                            rsp_rdata_n = rdata_q;
                        end
                        default: begin
                            state_n     = ST_IDLE;
                            rsp_valid_n = 1'b1;
                            rsp_err_n   = err_q;
                            rsp_rdata_n = 8'h00;
                        end
                    endcase
                end
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            step      <= 3'd0;
            lat_rd    <= 1'b0;
            lat_dev   <= 7'h00;
            lat_reg   <= 8'h00;
            lat_wdata <= 8'h00;
            rdata_q   <= 8'h00;
            err_q     <= ERR_OK;
            wait_cnt  <= 16'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= ERR_OK;
        end else begin
            state     <= state_n;
            step      <= step_n;
            lat_rd    <= lat_rd_n;
            lat_dev   <= lat_dev_n;
            lat_reg   <= lat_reg_n;
            lat_wdata <= lat_wdata_n;
            rdata_q   <= rdata_n;
            err_q     <= err_n;
            wait_cnt  <= wait_cnt_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
        end
    end

endmodule : i2c_sb_sequencer
`default_nettype wire

// File: tb/tb_i2c_sb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_sb_sequencer
// Description : Directed self-checking bench for i2c_sb_sequencer with a
//               behavioural SB model of the hard I2C IP.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_sb_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rd;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       sb_stb;
    logic       sb_rw;
    logic [7:0] sb_adr;
    logic [7:0] sb_wdat;
    logic [7:0] sb_rdat;
    logic       sb_ack = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    i2c_sb_sequencer #(
        .BUS_ADDR74     (4'b0001),
        .PRESCALE       (10'd60),
        .TIMEOUT_CYCLES (16'd100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rd    (cmd_rd),
        .cmd_dev   (cmd_dev),
        .cmd_reg   (cmd_reg),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .sb_stb    (sb_stb),
        .sb_rw     (sb_rw),
        .sb_adr    (sb_adr),
        .sb_wdat   (sb_wdat),
        .sb_rdat   (sb_rdat),
        .sb_ack    (sb_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- SB model of the hard IP ----------------
    logic        force_arbl = 1'b0;
    logic        force_rarc = 1'b0;
    logic        no_trrdy   = 1'b0;
    logic [7:0]  rxdr       = 8'h00;
    logic        phase      = 1'b0;
    logic [7:0]  sr_val;
    logic [15:0] wlog[$];
    int          rx_reads   = 0;
    int          cyc        = 0;

    // SR alternates busy / transfer-ready so each wait sees a retry
    always_comb begin
        if (force_arbl)      sr_val = 8'h08;
        else if (force_rarc) sr_val = 8'h24;
        else if (no_trrdy)   sr_val = 8'h40;
        else                 sr_val = phase ? 8'h04 : 8'h40;
        sb_rdat = 8'h00;
        if (sb_adr == 8'h1C)      sb_rdat = sr_val;
        else if (sb_adr == 8'h1E) sb_rdat = rxdr;
    end

    // Ack one cycle after the strobe is seen; log completed writes
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        sb_ack <= sb_stb && !sb_ack;
        if (sb_stb && sb_ack) begin
            if (sb_rw)                wlog.push_back({sb_adr, sb_wdat});
            else if (sb_adr == 8'h1C) phase <= ~phase;
            else if (sb_adr == 8'h1E) rx_reads <= rx_reads + 1;
        end
    end

    // Request stability while waiting for ack, and a gap after every ack
    logic        prev_stb = 1'b0;
    logic        prev_ack = 1'b0;
    logic [16:0] held     = '0;
    int          proto_viol = 0;
    always @(posedge clk) begin
        prev_stb <= sb_stb;
        prev_ack <= sb_stb && sb_ack;
        held     <= {sb_rw, sb_adr, sb_wdat};
        if ((sb_stb && prev_stb && !prev_ack && ({sb_rw, sb_adr, sb_wdat} != held)) ||
            (sb_stb && prev_ack))
            proto_viol <= proto_viol + 1;
    end

    int rsp_cnt = 0;
    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    logic [15:0] exp_w [8];
    int          accept_cyc;

    task automatic expect_writes(input string tag, input int n);
        check({tag, "_nwr"}, 32'(wlog.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_wr%0d", tag, i),
                  (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF, 32'(exp_w[i]));
        end
    endtask

    task automatic send_cmd(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                            input logic [7:0] wd, output int waited);
        cmd_rd    = rd;
        cmd_dev   = dev;
        cmd_reg   = ra;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        cmd_valid  = 1'b0;
        accept_cyc = cyc;
        check("ready_drop", 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_rsp(input string tag, output int lat);
        int n = 0;
        while (!rsp_valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
        check({tag, "_ready_with_rsp"}, 32'(cmd_ready), 32'd1);
        lat = cyc - accept_cyc;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int waited, lat, rx_snap, rsp_snap, n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_rd    = 1'b0;
        cmd_dev   = 7'h00;
        cmd_reg   = 8'h00;
        cmd_wdata = 8'h00;
        repeat (4) @(negedge clk);

        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_sb_stb",    32'(sb_stb),    32'd0);
        check("rst_sb_rw",     32'(sb_rw),     32'd0);
        check("rst_sb_adr",    32'(sb_adr),    32'd0);
        check("rst_sb_wdat",   32'(sb_wdat),   32'd0);

        // INIT programming; cmd_ready only once all three writes are acked
        wlog.delete();
        rst = 1'b0;
        wait_ready("init");
        exp_w = '{16'h1A3C, 16'h1B00, 16'h1880, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        expect_writes("init", 3);

        // Register write, all ACKed
        wlog.delete();
        send_cmd(1'b0, 7'h3C, 8'h12, 8'hA5, waited);
        wait_rsp("wr", lat);
        check("wr_err",   32'(rsp_err),   32'd0);
        check("wr_rdata", 32'(rsp_rdata), 32'd0);
        exp_w = '{16'h1D78, 16'h1994, 16'h1D12, 16'h1914, 16'h1DA5, 16'h1914, 16'h1944, 16'h0};
        expect_writes("wr", 7);

        // Register read returning 0x5A
        wlog.delete();
        rxdr    = 8'h5A;
        rx_snap = rx_reads;
        send_cmd(1'b1, 7'h24, 8'h00, 8'h00, waited);
        wait_rsp("rd", lat);
        check("rd_err",   32'(rsp_err),   32'd0);
        check("rd_rdata", 32'(rsp_rdata), 32'h5A);
        check("rd_rxdr_reads", 32'(rx_reads - rx_snap), 32'd1);
        exp_w = '{16'h1D48, 16'h1994, 16'h1D00, 16'h1914, 16'h1D49, 16'h1994, 16'h196C, 16'h0};
        expect_writes("rd", 7);

        // Address byte NACKed
        wlog.delete();
        force_rarc = 1'b1;
        send_cmd(1'b0, 7'h50, 8'h01, 8'h77, waited);
        wait_rsp("nack", lat);
        force_rarc = 1'b0;
        check("nack_err",   32'(rsp_err),   32'd1);
        check("nack_rdata", 32'(rsp_rdata), 32'd0);
        exp_w = '{16'h1DA0, 16'h1994, 16'h1944, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        expect_writes("nack", 3);

        // TRRDY never set: timeout after ~100 cycles of polling
        wlog.delete();
        no_trrdy = 1'b1;
        send_cmd(1'b0, 7'h3C, 8'h12, 8'hA5, waited);
        wait_rsp("tmo", lat);
        no_trrdy = 1'b0;
        check("tmo_err", 32'(rsp_err), 32'd2);
        check("tmo_latency_in_range", 32'(lat >= 100 && lat <= 125), 32'd1);
        exp_w = '{16'h1D78, 16'h1994, 16'h1944, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        expect_writes("tmo", 3);

        // Arbitration lost on a fresh command
        wlog.delete();
        force_arbl = 1'b1;
        send_cmd(1'b1, 7'h24, 8'h00, 8'h00, waited);
        wait_rsp("arbl", lat);
        force_arbl = 1'b0;
        check("arbl_err", 32'(rsp_err), 32'd3);
        exp_w = '{16'h1D48, 16'h1994, 16'h1944, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        expect_writes("arbl", 3);

        // Command offered in the response cycle is taken at once
        wlog.delete();
        send_cmd(1'b0, 7'h11, 8'h22, 8'h33, waited);
        check("b2b_accept_wait", 32'(waited), 32'd0);
        wait_rsp("b2b", lat);
        check("b2b_err", 32'(rsp_err), 32'd0);
        exp_w = '{16'h1D22, 16'h1994, 16'h1D22, 16'h1914, 16'h1D33, 16'h1914, 16'h1944, 16'h0};
        expect_writes("b2b", 7);

        // Reset during an SR poll strobe
        send_cmd(1'b0, 7'h3C, 8'h12, 8'hA5, waited);
        n = 0;
        while (!(sb_stb && sb_adr == 8'h1C) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_poll_found", 32'(sb_stb && sb_adr == 8'h1C), 32'd1);
        rst = 1'b1;
        rsp_snap = rsp_cnt;
        wlog.delete();
        @(negedge clk);
        check("mid_rst_sb_stb",    32'(sb_stb),    32'd0);
        check("mid_rst_sb_adr",    32'(sb_adr),    32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        wait_ready("reinit");
        exp_w = '{16'h1A3C, 16'h1B00, 16'h1880, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        expect_writes("reinit", 3);
        check("reinit_no_rsp", 32'(rsp_cnt - rsp_snap), 32'd0);

        check("sb_protocol_violations", 32'(proto_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_i2c_sb_sequencer
`default_nettype wire
